// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: per-source write requests in, registered register-file write out.
interface wb_port_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    logic                 wb_hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_wa;
    logic [NREQ*DW-1:0]   req_wd;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [DW-1:0]        rf_wd;
    logic [1:0]           grant_id;
    logic [15:0]          conflict_cnt;

    modport master (
        output wb_hold, req_valid, req_wa, req_wd,
        input  req_ready, rf_we, rf_wa, rf_wd, grant_id, conflict_cnt
    );

    modport slave (
        input  wb_hold, req_valid, req_wa, req_wd,
        output req_ready, rf_we, rf_wa, rf_wd, grant_id, conflict_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback sources.
// The winning write is registered and drives rf_* one cycle after the grant.
module wb_port_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned GW = 2;
    localparam int unsigned CW = 16;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_nxt;
    logic [PW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] ready_c;

    logic            we_q, we_nxt;
    logic [AW-1:0]   wa_q, wa_nxt, sel_wa;
    logic [DW-1:0]   wd_q, wd_nxt, sel_wd;
    logic [GW-1:0]   gid_q, gid_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            cnt_hit;

    // Scan from the pointer, wrapping, and take the first valid source.
    always_comb begin : arb
        int unsigned idx;
        found   = 1'b0;
        win     = '0;
        ready_c = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NREQ;
            if (!bus.wb_hold && !found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        if (found) begin
            ready_c[win] = 1'b1;
        end
    end

    // Next-state for pointer, output register and contention counter.
    always_comb begin : nxt
        int unsigned pop;
        sel_wa     = bus.req_wa[32'(win)*AW +: AW];
        sel_wd     = bus.req_wd[32'(win)*DW +: DW];
        rr_ptr_nxt = rr_ptr_q;
        we_nxt     = 1'b0;
        wa_nxt     = wa_q;
        wd_nxt     = wd_q;
        gid_nxt    = gid_q;
        pop        = 0;
        if (found) begin
            rr_ptr_nxt = (32'(win) == NREQ - 1) ? '0 : win + PW'(1);
            we_nxt     = (sel_wa != '0);
            wa_nxt     = sel_wa;
            wd_nxt     = sel_wd;
            gid_nxt    = GW'(win);
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            pop = pop + 32'(bus.req_valid[i]);
        end
        cnt_hit = bus.wb_hold ? (|bus.req_valid) : (pop >= 2);
        cnt_nxt = (cnt_hit && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            gid_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_nxt;
            we_q     <= we_nxt;
            wa_q     <= wa_nxt;
            wd_q     <= wd_nxt;
            gid_q    <= gid_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

    assign bus.req_ready    = ready_c;
    assign bus.rf_we        = we_q;
    assign bus.rf_wa        = wa_q;
    assign bus.rf_wd        = wd_q;
    assign bus.grant_id     = gid_q;
    assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed plan steps plus constrained-random traffic
// checked against a behavioural round-robin model and a model register file.
module tb_wb_port_arbiter;
    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wb_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int            m_ptr;
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_gid;
    int            m_cnt;
    int            last_win;
    logic [DW-1:0] mrf    [32];
    logic [DW-1:0] shadow [32];

    // Register file as seen from the DUT's write port
    always @(posedge clk) begin
        if (bus.rf_we) shadow[bus.rf_wa] <= bus.rf_wd;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic hold, input logic [NREQ-1:0] v);
        if (hold || v == '0) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_gid = 0; m_cnt = 0; last_win = -1;
    endtask

    task automatic step(input logic hold, input logic [NREQ-1:0] v,
                        input logic [NREQ*AW-1:0] wa, input logic [NREQ*DW-1:0] wd,
                        input bit chk);
        int w;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        bus.wb_hold = hold; bus.req_valid = v; bus.req_wa = wa; bus.req_wd = wd;
        #1;
        w = model_winner(hold, v);
        exp_ready = (w < 0) ? '0 : NREQ'(1) << w;
        if (chk) check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (m_we) mrf[m_wa] = m_wd;
        m_we = 1'b0;
        if (w >= 0) begin
            m_wa  = wa[w*AW +: AW];
            m_wd  = wd[w*DW +: DW];
            m_we  = (m_wa != 0);
            m_gid = w;
            m_ptr = (w + 1) % NREQ;
        end
        if (hold ? (v != 0) : ($countones(v) >= 2)) begin
            if (m_cnt < 65535) m_cnt++;
        end
        last_win = w;
        @(posedge clk);
        #1;
        if (chk) begin
            check("rf_we", 64'(bus.rf_we), 64'(m_we));
            check("rf_wa", 64'(bus.rf_wa), 64'(m_wa));
            check("rf_wd", 64'(bus.rf_wd), 64'(m_wd));
            check("grant_id", 64'(bus.grant_id), 64'(m_gid));
            check("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_cnt));
        end
    endtask

    function automatic logic [NREQ*AW-1:0] pk_wa(input int a0, input int a1, input int a2);
        pk_wa = {AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [NREQ*DW-1:0] pk_wd(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                                 input logic [DW-1:0] d2);
        pk_wd = {d2, d1, d0};
    endfunction

    logic [NREQ-1:0]    pv;
    logic [NREQ*AW-1:0] pwa;
    logic [NREQ*DW-1:0] pwd;
    int                 grants [$];

    initial begin
        checks = 0; errors = 0;
        for (int i = 0; i < 32; i++) begin mrf[i] = '0; shadow[i] = '0; end
        rst_n = 1'b0;
        bus.wb_hold = 1'b0; bus.req_valid = '0; bus.req_wa = '0; bus.req_wd = '0;
        model_reset();
        #1;
        check("rst_rf_we", 64'(bus.rf_we), 64'd0);
        check("rst_rf_wa", 64'(bus.rf_wa), 64'd0);
        check("rst_rf_wd", 64'(bus.rf_wd), 64'd0);
        check("rst_grant_id", 64'(bus.grant_id), 64'd0);
        check("rst_conflict", 64'(bus.conflict_cnt), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Single ALU write, then idle
        step(1'b0, 3'b001, pk_wa(5, 0, 0), pk_wd(32'hDEADBEEF, 0, 0), 1'b1);
        check("t1_we", 64'(bus.rf_we), 64'd1);
        check("t1_wd", 64'(bus.rf_wd), 64'hDEADBEEF);
        step(1'b0, 3'b000, '0, '0, 1'b1);
        check("t1_we_drop", 64'(bus.rf_we), 64'd0);

        // All three continuously valid from reset: grants rotate 0,1,2,0,1,2
        @(negedge clk); rst_n = 1'b0; #1; model_reset();
        @(negedge clk); rst_n = 1'b1;
        grants.delete();
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 3'b111, pk_wa(10 + c, 20 + c, 30), pk_wd(DW'(c), DW'(c + 100), DW'(c + 200)), 1'b1);
            grants.push_back(int'(bus.grant_id));
        end
        for (int c = 0; c < 6; c++) check("t2_grant_seq", 64'(grants[c]), 64'(c % 3));
        check("t2_conflict6", 64'(bus.conflict_cnt), 64'd6);

        // Write to r0 is accepted but not enabled
        step(1'b0, 3'b010, pk_wa(0, 0, 0), pk_wd(0, 32'h1234, 0), 1'b1);
        check("t3_we0", 64'(bus.rf_we), 64'd0);
        check("t3_gid1", 64'(bus.grant_id), 64'd1);

        // Hold stalls source 2 for four cycles, then it goes through
        for (int c = 0; c < 4; c++) step(1'b1, 3'b100, pk_wa(0, 0, 9), pk_wd(0, 0, 32'hCAFE), 1'b1);
        check("t4_conflict", 64'(bus.conflict_cnt), 64'd10);
        step(1'b0, 3'b100, pk_wa(0, 0, 9), pk_wd(0, 0, 32'hCAFE), 1'b1);
        check("t4_gid2", 64'(bus.grant_id), 64'd2);
        step(1'b0, 3'b000, '0, '0, 1'b1);

        // Reset during the output-register cycle discards the pending write
        step(1'b0, 3'b001, pk_wa(7, 0, 0), pk_wd(1, 0, 0), 1'b1);
        #2; rst_n = 1'b0; bus.req_valid = '0;
        #1;
        check("t5_we_killed", 64'(bus.rf_we), 64'd0);
        check("t5_cnt_cleared", 64'(bus.conflict_cnt), 64'd0);
        model_reset();
        m_wa = '0; m_wd = '0;
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        step(1'b0, 3'b011, pk_wa(3, 4, 0), pk_wd(32'h11, 32'h22, 0), 1'b1);
        check("t5_src0_wins", 64'(bus.grant_id), 64'd0);
        check("t5_r7_unwritten", 64'(shadow[7]), 64'd0);

        // Random traffic; each source holds its request until granted
        pv = '0; pwa = '0; pwd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < NREQ; s++) begin
                if (!pv[s] && ($urandom_range(1, 0) == 1)) begin
                    pv[s] = 1'b1;
                    pwa[s*AW +: AW] = AW'($urandom_range(31, 0));
                    pwd[s*DW +: DW] = $urandom;
                end
            end
            step(($urandom_range(3, 0) == 0), pv, pwa, pwd, 1'b1);
            if (last_win >= 0) pv[last_win] = 1'b0;
        end
        step(1'b0, 3'b000, '0, '0, 1'b1);

        // Sustained contention drives the counter into saturation
        for (int c = 0; c < 65540; c++) begin
            step(1'b0, 3'b011, pk_wa(12, 13, 0), pk_wd(32'hA, 32'hB, 0), (c >= 65530));
        end
        check("t6_saturated", 64'(bus.conflict_cnt), 64'hFFFF);
        step(1'b1, 3'b001, pk_wa(12, 0, 0), pk_wd(32'hA, 0, 0), 1'b1);
        check("t6_held_sat", 64'(bus.conflict_cnt), 64'hFFFF);
        step(1'b0, 3'b000, '0, '0, 1'b1);
        step(1'b0, 3'b000, '0, '0, 1'b1);

        // Register file contents written through the port match the model's ordering
        for (int i = 0; i < 32; i++) check("rf_contents", 64'(shadow[i]), 64'(mrf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
